// File: rtl/sequencer_fsa.sv
// One-hot 24-state timing automaton that paces each instruction, with derived pulses pA..pT and run/halt/step control.
// Optional instruction counter output enabled by defining INSTR_COUNT_EN.
module sequencer_fsa #(
  localparam int unsigned NUM_STATES = 24,
  localparam int unsigned NUM_PULSES = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic                  abort_8,
  input  logic                  abort_12,
  input  logic                  abort_14,
  output logic [NUM_STATES-1:0] fsa_out,
  output logic [NUM_PULSES-1:0] pulse_out,
  output logic                  running,
  output logic                  cycle_done
`ifdef INSTR_COUNT_EN
  ,
  output logic [15:0]           instr_count
`endif
);

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } ctrl_state_t;

  ctrl_state_t ctrl_state;
  logic        step_mode;
  logic        stop_after;

  // An abort only matters in its own end state; the one-hot state makes the earliest end win naturally.
  always_comb begin
    cycle_done = (fsa_out[7]  & abort_8)
               | (fsa_out[11] & abort_12)
               | (fsa_out[13] & abort_14)
               | fsa_out[NUM_STATES-1];
    stop_after = halt_req | step_mode | ~run;
  end

  assign running = (ctrl_state == RUNNING);

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_state <= HALTED;
      fsa_out    <= '0;
      step_mode  <= 1'b0;
    end else if (ctrl_state == HALTED) begin
      if (run | step) begin
        ctrl_state <= RUNNING;
        fsa_out    <= NUM_STATES'(1);
        step_mode  <= step & ~run;
      end
    end else begin
      if (cycle_done) begin
        if (stop_after) begin
          ctrl_state <= HALTED;
          fsa_out    <= '0;
        end else begin
          fsa_out <= NUM_STATES'(1);
        end
      end else begin
        fsa_out <= {fsa_out[NUM_STATES-2:0], 1'b0};
      end
    end
  end

  // Pulse decodes; truncation at a shortened end state falls out of the state never advancing further.
  always_comb begin
    pulse_out     = '0;
    pulse_out[0]  = |fsa_out[3:0];
    pulse_out[1]  = |fsa_out[2:1];
    pulse_out[2]  = |fsa_out[6:4];
    pulse_out[3]  = fsa_out[5];
    pulse_out[4]  = |fsa_out[9:8];
    pulse_out[5]  = |fsa_out[13:8];
    pulse_out[6]  = |fsa_out[12:9];
    pulse_out[7]  = |fsa_out[11:10];
    pulse_out[8]  = |fsa_out[12:11];
    pulse_out[9]  = |fsa_out[19:12];
    pulse_out[10] = |fsa_out[18:13];
    pulse_out[11] = |fsa_out[21:14];
    pulse_out[12] = |fsa_out[20:15];
    pulse_out[13] = |fsa_out[19:16];
    pulse_out[14] = |fsa_out[18:17];
    pulse_out[15] = fsa_out[18];
    pulse_out[16] = |fsa_out[23:20];
    pulse_out[17] = |fsa_out[22:21];
    pulse_out[18] = fsa_out[22];
    pulse_out[19] = fsa_out[23];
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      instr_count <= '0;
    end else if (cycle_done) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sequencer_fsa.sv
// Directed bench for sequencer_fsa: walks instructions state by state against a pulse-range table.
module tb_sequencer_fsa;

  logic        clock = 1'b0;
  logic        reset, run, step, halt_req, abort_8, abort_12, abort_14;
  logic [23:0] fsa_out;
  logic [19:0] pulse_out;
  logic        running, cycle_done;
`ifdef INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int checks   = 0;
  int failures = 0;
  int pa_hits  = 0;

  int pulse_lo[20] = '{0, 1, 4, 5, 8, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 20, 21, 22, 23};
  int pulse_hi[20] = '{3, 2, 6, 5, 9, 13, 12, 11, 12, 19, 18, 21, 20, 19, 18, 18, 23, 22, 22, 23};

  sequencer_fsa dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .halt_req   (halt_req),
    .abort_8    (abort_8),
    .abort_12   (abort_12),
    .abort_14   (abort_14),
    .fsa_out    (fsa_out),
    .pulse_out  (pulse_out),
    .running    (running),
    .cycle_done (cycle_done)
`ifdef INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] exp_pulses(input int s);
    logic [19:0] p;
    p = '0;
    for (int i = 0; i < 20; i++)
      if (s >= pulse_lo[i] && s <= pulse_hi[i]) p[i] = 1'b1;
    return p;
  endfunction

  // s < 0 means halted
  task automatic expect_state(input int s, input logic done);
    logic [23:0] e;
    e = '0;
    if (s >= 0) e[s] = 1'b1;
    check($sformatf("fsa_s%0d", s), 32'(fsa_out), 32'(e));
    check($sformatf("pulse_s%0d", s), 32'(pulse_out), 32'(exp_pulses(s)));
    check($sformatf("running_s%0d", s), 32'(running), 32'(s >= 0));
    check($sformatf("done_s%0d", s), 32'(cycle_done), 32'(done));
    if (pulse_out[0]) pa_hits++;
  endtask

  task automatic walk(input int from, input int to, input int end_s);
    for (int k = from; k <= to; k++) begin
      @(negedge clock);
      expect_state(k, k == end_s);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    abort_8 = 1'b0; abort_12 = 1'b0; abort_14 = 1'b0;
    repeat (3) @(negedge clock);
    expect_state(-1, 1'b0);
`ifdef INSTR_COUNT_EN
    check("count_reset", 32'(instr_count), 32'd0);
`endif

    // free run, full length, wrap with no gap
    reset = 1'b0; run = 1'b1;
    walk(0, 23, 23);
    walk(0, 0, 23);

    // abort at S7; pA high for 4 of 8 states
    abort_8 = 1'b1;
    walk(1, 7, 7);
    pa_hits = 0;
    walk(0, 7, 7);
    check("pa_hits_abort8", 32'(pa_hits), 32'd4);
    walk(0, 0, 7);

    // abort_12 and abort_14 together end at S11, pF truncated
    abort_8 = 1'b0; abort_12 = 1'b1; abort_14 = 1'b1;
    walk(1, 11, 11);
    walk(0, 0, 11);

    // run dropped at S5 completes the instruction then halts
    abort_12 = 1'b0; abort_14 = 1'b0;
    walk(1, 5, 23);
    run = 1'b0;
    walk(6, 23, 23);
    walk(-1, -1, 23);

    // single step; a second step while running is ignored
    step = 1'b1;
    walk(0, 0, 23);
    step = 1'b0;
    walk(1, 3, 23);
    step = 1'b1;
    walk(4, 4, 23);
    step = 1'b0;
    walk(5, 23, 23);
    walk(-1, -1, 23);
    walk(-1, -1, 23);

    // step held high: one instruction per halted visit
    step = 1'b1;
    walk(0, 23, 23);
    walk(-1, -1, 23);
    walk(0, 0, 23);
    step = 1'b0;
    walk(1, 23, 23);
    walk(-1, -1, 23);

    // halt_req raised at S20 wins over run
    run = 1'b1;
    walk(0, 20, 23);
    halt_req = 1'b1;
    walk(21, 23, 23);
    walk(-1, -1, 23);
    halt_req = 1'b0;
    walk(0, 0, 23);

    // reset at S10 abandons the instruction
    walk(1, 10, 23);
    reset = 1'b1;
    walk(-1, -1, 23);

`ifdef INSTR_COUNT_EN
    check("count_after_reset", 32'(instr_count), 32'd0);
    reset = 1'b0;
    walk(0, 23, 23);
    walk(0, 23, 23);
    walk(0, 23, 23);
    walk(0, 0, 23);
    check("count_three", 32'(instr_count), 32'd3);
    run = 1'b0;
    walk(1, 23, 23);
    walk(-1, -1, 23);
    walk(-1, -1, 23);
    check("count_hold_halted", 32'(instr_count), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
